// File: rtl/unidade_controle_if.sv
// rtl/unidade_controle_if.sv - control/status bundle between the game FSM and its datapath
interface unidade_controle_if;
  logic zeraC;
  logic contaC;
  logic zeraR;
  logic registraR;
  logic conta;
  logic jogada_feita;
  logic igual;
  logic fimC;
  logic fimT;

  modport master (
    output zeraC, contaC, zeraR, registraR, conta,
    input  jogada_feita, igual, fimC, fimT
  );

  modport slave (
    input  zeraC, contaC, zeraR, registraR, conta,
    output jogada_feita, igual, fimC, fimT
  );
endinterface

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - Moore FSM sequencing one 16-move round against the ROM
module unidade_controle #(
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciar,
  unidade_controle_if.master        dp,
  output logic                      pronto,
  output logic                      acertou,
  output logic                      errou,
  output logic                      timeout,
  output logic [3:0]                db_estado
);

  typedef enum logic [3:0] {
    st_inicial     = 4'h0,
    st_preparacao  = 4'h1,
    st_espera      = 4'h2,
    st_registra    = 4'h4,
    st_comparacao  = 4'h5,
    st_proximo     = 4'h6,
    st_fim_acertou = 4'hA,
    st_fim_timeout = 4'hD,
    st_fim_errou   = 4'hE
  } estado_t;

  estado_t estado_q;
  estado_t estado_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado_q <= st_inicial;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d     = st_inicial;
    dp.zeraC     = 1'b0;
    dp.contaC    = 1'b0;
    dp.zeraR     = 1'b0;
    dp.registraR = 1'b0;
    dp.conta     = 1'b0;
    pronto       = 1'b0;
    acertou      = 1'b0;
    errou        = 1'b0;
    timeout      = 1'b0;
    db_estado    = estado_q;

    case (estado_q)
      st_inicial: estado_d = iniciar ? st_preparacao : st_inicial;
      st_preparacao: begin
        dp.zeraC = 1'b1;
        dp.zeraR = 1'b1;
        estado_d = st_espera;
      end
      st_espera: begin
        dp.conta = 1'b1;
        // a move arriving on the same edge as the timer expiry still counts
        if (dp.jogada_feita)            estado_d = st_registra;
        else if (dp.fimT && TIMEOUT_EN) estado_d = st_fim_timeout;
        else                            estado_d = st_espera;
      end
      st_registra: begin
        dp.registraR = 1'b1;
        estado_d     = st_comparacao;
      end
      st_comparacao: begin
        if (!dp.igual)    estado_d = st_fim_errou;
        else if (dp.fimC) estado_d = st_fim_acertou;
        else              estado_d = st_proximo;
      end
      st_proximo: begin
        dp.contaC = 1'b1;
        estado_d  = st_espera;
      end
      st_fim_acertou: begin
        pronto   = 1'b1;
        acertou  = 1'b1;
        estado_d = iniciar ? st_preparacao : st_fim_acertou;
      end
      st_fim_errou: begin
        pronto   = 1'b1;
        errou    = 1'b1;
        estado_d = iniciar ? st_preparacao : st_fim_errou;
      end
      st_fim_timeout: begin
        pronto   = 1'b1;
        timeout  = 1'b1;
        estado_d = iniciar ? st_preparacao : st_fim_timeout;
      end
      default: estado_d = st_inicial;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - scoreboard bench for unidade_controle
module tb_unidade_controle;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar_a = 1'b0;
  logic iniciar_b = 1'b0;
  logic pronto_a, acertou_a, errou_a, timeout_a;
  logic pronto_b, acertou_b, errou_b, timeout_b;
  logic [3:0] db_estado_a, db_estado_b;

  unidade_controle_if dp_a ();
  unidade_controle_if dp_b ();

  unidade_controle #(.TIMEOUT_EN(1'b1)) dut_a (
    .clock(clock), .reset(reset), .iniciar(iniciar_a), .dp(dp_a),
    .pronto(pronto_a), .acertou(acertou_a), .errou(errou_a), .timeout(timeout_a),
    .db_estado(db_estado_a)
  );

  unidade_controle #(.TIMEOUT_EN(1'b0)) dut_b (
    .clock(clock), .reset(reset), .iniciar(iniciar_b), .dp(dp_b),
    .pronto(pronto_b), .acertou(acertou_b), .errou(errou_b), .timeout(timeout_b),
    .db_estado(db_estado_b)
  );

  always #5 clock = ~clock;

  // {db_estado, zeraC, contaC, zeraR, registraR, conta, pronto, acertou, errou, timeout}
  logic [12:0] obs_a, obs_b;
  assign obs_a = {db_estado_a, dp_a.zeraC, dp_a.contaC, dp_a.zeraR, dp_a.registraR, dp_a.conta,
                  pronto_a, acertou_a, errou_a, timeout_a};
  assign obs_b = {db_estado_b, dp_b.zeraC, dp_b.contaC, dp_b.zeraR, dp_b.registraR, dp_b.conta,
                  pronto_b, acertou_b, errou_b, timeout_b};

  typedef struct {
    string       tag;
    bit          sel_b;
    logic [12:0] vec;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   conta_c_pulses = 0;

  function automatic logic [12:0] exp_of(input logic [3:0] s);
    case (s)
      4'h0:    return {s, 9'b000000000};
      4'h1:    return {s, 9'b101000000};
      4'h2:    return {s, 9'b000010000};
      4'h4:    return {s, 9'b000100000};
      4'h5:    return {s, 9'b000000000};
      4'h6:    return {s, 9'b010000000};
      4'hA:    return {s, 9'b000001100};
      4'hE:    return {s, 9'b000001010};
      4'hD:    return {s, 9'b000001001};
      default: return 13'h1fff;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [12:0] got, input logic [12:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_empty got=0 exp=1");
      return;
    end
    e = sb.pop_front();
    check_val(e.tag, e.sel_b ? obs_b : obs_a, e.vec);
  endtask

  task automatic drive_a(input logic ini, input logic jf, input logic ig, input logic fc, input logic ft);
    iniciar_a         = ini;
    dp_a.jogada_feita = jf;
    dp_a.igual        = ig;
    dp_a.fimC         = fc;
    dp_a.fimT         = ft;
  endtask

  task automatic cyc(input string tag, input bit sel_b, input logic [3:0] exp_state);
    exp_t e;
    e.tag = tag; e.sel_b = sel_b; e.vec = exp_of(exp_state);
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (!sel_b && dp_a.contaC) conta_c_pulses++;
    pop_compare();
  endtask

  task automatic play_move(input string tag, input logic ig, input logic last);
    drive_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); cyc({tag, "_reg"}, 1'b0, 4'h4);
    drive_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); cyc({tag, "_cmp"}, 1'b0, 4'h5);
    drive_a(1'b0, 1'b0, ig, last, 1'b0);
    if (!ig)       cyc({tag, "_err"}, 1'b0, 4'hE);
    else if (last) cyc({tag, "_ok"}, 1'b0, 4'hA);
    else begin
      cyc({tag, "_prox"}, 1'b0, 4'h6);
      drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc({tag, "_esp"}, 1'b0, 4'h2);
    end
  endtask

  task automatic start_round(input string tag);
    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc({tag, "_prep"}, 1'b0, 4'h1);
    drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc({tag, "_esp"}, 1'b0, 4'h2);
  endtask

  initial begin
    exp_t e;
    drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dp_b.jogada_feita = 1'b0; dp_b.igual = 1'b0; dp_b.fimC = 1'b0; dp_b.fimT = 1'b0;
    #2;
    e.tag = "reset_state"; e.sel_b = 1'b0; e.vec = exp_of(4'h0);
    sb.push_back(e); pop_compare();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    for (int i = 0; i < 3; i++) cyc("idle_inicial", 1'b0, 4'h0);
    start_round("start");

    conta_c_pulses = 0;
    for (int i = 0; i < 16; i++) play_move("full", 1'b1, i == 15);
    check_val("full_contaC_count", 13'(conta_c_pulses), 13'd15);
    drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc("acertou_hold", 1'b0, 4'hA);

    start_round("err_start");
    conta_c_pulses = 0;
    play_move("err_m1", 1'b1, 1'b0);
    play_move("err_m2", 1'b1, 1'b0);
    play_move("err_m3", 1'b0, 1'b0);
    check_val("err_contaC_count", 13'(conta_c_pulses), 13'd2);
    drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc("errou_hold", 1'b0, 4'hE);

    start_round("restart");
    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc("iniciar_ignored_espera", 1'b0, 4'h2);
    drive_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b1); cyc("jf_beats_fimT", 1'b0, 4'h4);
    drive_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); cyc("sim_cmp", 1'b0, 4'h5);
    cyc("sim_prox", 1'b0, 4'h6);
    drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc("sim_esp", 1'b0, 4'h2);
    cyc("espera_hold", 1'b0, 4'h2);
    drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc("timeout", 1'b0, 4'hD);
    drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc("timeout_hold", 1'b0, 4'hD);

    start_round("after_timeout");
    #1 reset = 1'b0;
    #2;
    e.tag = "async_reset"; e.sel_b = 1'b0; e.vec = exp_of(4'h0);
    sb.push_back(e); pop_compare();
    @(posedge clock);
    #1 reset = 1'b1;
    cyc("post_reset_idle", 1'b0, 4'h0);

    iniciar_b = 1'b1; cyc("noto_prep", 1'b1, 4'h1);
    iniciar_b = 1'b0; cyc("noto_esp", 1'b1, 4'h2);
    dp_b.fimT = 1'b1;
    for (int i = 0; i < 3; i++) cyc("noto_fimT_ignored", 1'b1, 4'h2);
    dp_b.fimT = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Moore control FSM that sits directly upstream of the game datapath and drives its control inputs: zeraC, contaC, zeraR, registraR, conta.
- Consumes the datapath status: igual, fimC, jogada_feita, fimT.
- Sequences one round: up to 16 player moves are compared against the ROM in order.
- The round ends on full success, the first mismatch, or timeout. It publishes pronto/acertou/errou/timeout and a state code for the hex display.

Parameters:
TIMEOUT_EN, 1, when 1 fimT in espera ends the round as timeout; when 0 fimT is ignored.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; low forces state inicial immediately
iniciar  input  1  start/restart request (level, sampled each edge)
jogada_feita  input  1  one-cycle pulse from datapath edge detector
igual  input  1  ROM word equals registered jogada
fimC  input  1  address counter at last position (15)
fimT  input  1  timeout counter terminal count
zeraC  output  1  clear address counter, timeout counter and edge detector
contaC  output  1  increment address counter
zeraR  output  1  clear jogada register
registraR  output  1  load jogada register from chaves
conta  output  1  enable timeout counter
pronto  output  1  round finished (any outcome)
acertou  output  1  round finished, all 16 correct
errou  output  1  round finished on mismatch
timeout  output  1  round finished on timeout
db_estado  output  4  current state code

Behaviour:
- Single registered state; asynchronous clear to inicial when reset=0.
- Outputs are a pure decode of the state (Moore), so outputs change one cycle after the input that causes a transition.
- Reset values: all outputs 0, db_estado=4'h0.
- States (db_estado code), active outputs, and transitions evaluated at each rising edge:
  - inicial (0): no outputs. iniciar=1 -> preparacao; else stay.
  - preparacao (1): zeraC=1, zeraR=1. -> espera unconditionally.
  - espera (2): conta=1.
    - jogada_feita=1 -> registra.
    - else fimT=1 and TIMEOUT_EN=1 -> fim_timeout.
    - else stay.
    - jogada_feita has priority over a simultaneous fimT.
  - registra (4): registraR=1. -> comparacao.
  - comparacao (5): no outputs.
    - igual=0 -> fim_errou.
    - else fimC=1 -> fim_acertou.
    - else -> proximo.
  - proximo (6): contaC=1. -> espera.
  - fim_acertou (A): pronto=1, acertou=1.
  - fim_errou (E): pronto=1, errou=1.
  - fim_timeout (D): pronto=1, timeout=1.
  - All three fim states: iniciar=1 -> preparacao; else stay.
- Unused encodings -> inicial on the next edge, with all outputs 0.
- Datapath timing relied on:
  - The ROM is synchronous: the address increments at the end of proximo and data is valid one edge later.
  - At least one cycle is always spent in espera, so igual is valid by comparacao.
- Timer restart between moves comes from jogada_feita inside the datapath. The FSM does not pulse zeraC between moves.
- iniciar held high in inicial or a fim state: the round restarts and proceeds normally. iniciar is ignored in every other state.
- reset low mid-round: outputs drop to 0 asynchronously. On release, the FSM waits in inicial; no datapath state is assumed.

Test Plan:
1. Reset/start: reset=0 then 1, iniciar=0 for 3 cycles -> db_estado=0, all outputs 0. Pulse iniciar -> sequence 1,2 with zeraC=zeraR=1 for exactly one cycle.
2. Full success: 16 jogada_feita pulses, igual=1 throughout, fimC=1 only on the 16th comparacao -> 15 contaC pulses, then db_estado=A, pronto=acertou=1, errou=timeout=0.
3. Error: igual=1 for moves 1-2, igual=0 on move 3 -> exactly 2 contaC pulses, then db_estado=E, pronto=errou=1.
4. Timeout: after move 1, no jogada_feita; assert fimT -> next edge db_estado=D, timeout=pronto=1. With TIMEOUT_EN=0 the FSM stays in 2.
5. Simultaneous jogada_feita=1 and fimT=1 in espera -> state 4 with registraR=1, no timeout.
6. Restart and mid-run reset: from fim_errou pulse iniciar -> state 1 then 2. Drive reset=0 while in state 2 -> outputs 0 before the next clock edge, db_estado=0.
